snn_step_scheduler: RTL and testbench
=====================================

Name: snn_step_scheduler

Overview:
Time-multiplexed synapse controller for the spiking network. On each simulation timestep it walks the INPUTNUM x EXCNUM synapse matrix through one shared signed accumulator, reading weights from an external weight RAM. It gates each weight by the latched pre-synaptic spike and presents one saturated membrane-input sum per excitatory neuron. It replaces the fully parallel synapse bank plus adder trees with a sequenced datapath that the exc_neuron stage consumes one result at a time.

Parameters:
DW, 16, fractional data width
INT_DW, 8, integer data width; weight and sum width is W = DW+INT_DW (24)
INPUTNUM, 4, number of input (pre-synaptic) neurons
EXCNUM, 2, number of excitatory (post-synaptic) neurons

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
en  in  1  global enable; low freezes all state
step_start  in  1  single-cycle pulse that starts one timestep
pre_spike  in  INPUTNUM  input-neuron spikes, sampled when step_start is accepted
wt_rd_en  out  1  weight RAM read strobe
wt_addr  out  clog2(INPUTNUM*EXCNUM)  weight address = j*INPUTNUM + i
wt_data  in  W  signed weight; valid the cycle after wt_rd_en; RAM holds wt_data while wt_rd_en is low
acc_valid  out  1  one-cycle pulse; acc_sum/acc_idx valid
acc_idx  out  clog2(EXCNUM) (min 1)  excitatory neuron index j
acc_sum  out  W  signed saturated sum for neuron j
busy  out  1  high whenever state != IDLE
step_done  out  1  one-cycle pulse, coincident with the last acc_valid
step_overrun  out  1  one-cycle pulse when step_start arrives while busy

Behaviour:
- Reset (async, rst=1): state IDLE; i, j, accumulator and spike latch cleared; all outputs 0, including acc_sum and acc_idx.
- en=0: state, counters and accumulator hold; wt_rd_en, acc_valid, step_done and step_overrun forced 0. The step resumes exactly where it stopped when en returns high.
- IDLE: on step_start & en, latch pre_spike into spk_q, set j=0, i=0, acc=0, go to RUN.
- RUN, per neuron j, with counter i running 0..INPUTNUM:
  - When i<INPUTNUM: wt_rd_en=1, wt_addr=j*INPUTNUM+i.
  - When i>=1: acc += spk_q[i-1] ? wt_data : 0.
  - When i==INPUTNUM: go to EMIT.
- EMIT (1 cycle): acc_valid=1, acc_idx=j, acc_sum=sat(acc). Then clear acc and i.
  - If j==EXCNUM-1: step_done=1, go to IDLE.
  - Else: j++, go to RUN.
- acc_sum and acc_idx hold their last emitted value until the next EMIT.
- Arithmetic:
  - Accumulator width is W+clog2(INPUTNUM), signed, so no internal overflow is possible.
  - Output saturates to [-2^(W-1), 2^(W-1)-1].
- Timing (cycle 0 = step_start accepted):
  - First acc_valid at cycle INPUTNUM+2 (6).
  - Neuron j is emitted at cycle (j+1)*(INPUTNUM+2).
  - The step completes at cycle EXCNUM*(INPUTNUM+2) (12), after which busy drops.
- step_start while busy, including the EMIT/step_done cycle: ignored and step_overrun pulses. A step_start in the cycle after step_done is accepted.
- pre_spike changes during a step have no effect; only the latched spk_q is used.
- All-zero spikes: the full sequence still runs and each acc_sum is 0.
- rst asserted mid-step: immediate return to IDLE with no acc_valid or step_done for the aborted step.

Test Plan:
1. Weights loaded at addr0..7 = 1615585, 2564138, -88929, 568763, 592018, -153494, 3681132, 2266863; pre_spike=4'b0011; step_start → acc_valid at cycle 6 with idx0 sum 4179723; at cycle 12 idx1 sum 438524 plus step_done; busy high for cycles 1..12.
2. Same weights, pre_spike=4'b1111 → idx0 sum 4659557, idx1 sum 6386519; pre_spike=0 → both sums 0; wt_addr sequence is exactly 0,1,2,3,4,5,6,7.
3. Saturation: all weights 8388607 with all spikes → both sums 8388607; all weights -8388608 → both sums -8388608.
4. step_start pulsed at cycle 3 of an active step → step_overrun pulse and results unchanged from scenario 1; step_start in the cycle after step_done → new step starts normally.
5. en held low for 5 cycles mid-RUN → outputs frozen and wt_rd_en=0; results and ordering identical to scenario 1, delayed by 5 cycles.
6. rst asserted at cycle 4, then released → busy=0 and acc_sum=0 immediately; no acc_valid; the next step_start produces correct scenario 1 results.

Source files
------------

// File: rtl/snn_step_scheduler_if.sv
// Handshake and datapath bundle between the synapse step scheduler and its
// controller/weight-RAM side.
interface snn_step_scheduler_if #(
  parameter int unsigned DW       = 16,
  parameter int unsigned INT_DW   = 8,
  parameter int unsigned INPUTNUM = 4,
  parameter int unsigned EXCNUM   = 2
);
  localparam int unsigned W     = DW + INT_DW;
  localparam int unsigned AddrW = (INPUTNUM * EXCNUM > 1) ? $clog2(INPUTNUM * EXCNUM) : 1;
  localparam int unsigned IdxW  = (EXCNUM > 1) ? $clog2(EXCNUM) : 1;

  logic                 en;
  logic                 step_start;
  logic [INPUTNUM-1:0]  pre_spike;
  logic                 wt_rd_en;
  logic [AddrW-1:0]     wt_addr;
  logic signed [W-1:0]  wt_data;
  logic                 acc_valid;
  logic [IdxW-1:0]      acc_idx;
  logic signed [W-1:0]  acc_sum;
  logic                 busy;
  logic                 step_done;
  logic                 step_overrun;

  modport master (
    output en, step_start, pre_spike, wt_data,
    input  wt_rd_en, wt_addr, acc_valid, acc_idx, acc_sum, busy, step_done, step_overrun
  );

  modport slave (
    input  en, step_start, pre_spike, wt_data,
    output wt_rd_en, wt_addr, acc_valid, acc_idx, acc_sum, busy, step_done, step_overrun
  );
endinterface

// File: rtl/snn_step_scheduler.sv
// Time-multiplexed synapse controller: walks the INPUTNUM x EXCNUM weight matrix
// through one signed accumulator and emits one saturated sum per excitatory neuron.
module snn_step_scheduler #(
  parameter int unsigned DW       = 16,
  parameter int unsigned INT_DW   = 8,
  parameter int unsigned INPUTNUM = 4,
  parameter int unsigned EXCNUM   = 2
) (
  input logic                 clk,
  input logic                 rst,
  snn_step_scheduler_if.slave bus
);
  localparam int unsigned W     = DW + INT_DW;
  localparam int unsigned AccW  = W + $clog2(INPUTNUM);
  localparam int unsigned AddrW = (INPUTNUM * EXCNUM > 1) ? $clog2(INPUTNUM * EXCNUM) : 1;
  localparam int unsigned IdxW  = (EXCNUM > 1) ? $clog2(EXCNUM) : 1;
  localparam int unsigned CntW  = $clog2(INPUTNUM + 1);

  localparam logic [CntW-1:0] ILast = CntW'(INPUTNUM);
  localparam logic [IdxW-1:0] JLast = IdxW'(EXCNUM - 1);

  localparam logic signed [AccW-1:0] SatMax = AccW'((64'sd1 <<< (W - 1)) - 64'sd1);
  localparam logic signed [AccW-1:0] SatMin = ~SatMax;

  typedef enum logic [1:0] {StIdle, StRun, StEmit} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        i_q, i_d;
  logic [IdxW-1:0]        j_q, j_d;
  logic signed [AccW-1:0] acc_q, acc_d;
  logic [INPUTNUM-1:0]    spk_q, spk_d;
  logic signed [W-1:0]    sum_q, sum_d;
  logic [IdxW-1:0]        idx_q, idx_d;

  logic                   spk_sel;
  logic signed [AccW-1:0] wt_term, acc_next;
  logic [AddrW-1:0]       addr;
  logic                   rd_en, valid, done, overrun;

  function automatic logic signed [W-1:0] sat(input logic signed [AccW-1:0] x);
    if (x > SatMax) begin
      sat = SatMax[W-1:0];
    end else if (x < SatMin) begin
      sat = SatMin[W-1:0];
    end else begin
      sat = x[W-1:0];
    end
  endfunction

  // Weight read in cycle i lands in cycle i+1, so it is gated by spike i-1.
  always_comb begin
    spk_sel = 1'b0;
    for (int k = 0; k < INPUTNUM; k++) begin
      if (i_q == CntW'(k + 1)) spk_sel = spk_q[k];
    end
    wt_term  = (i_q != '0 && spk_sel) ? AccW'(bus.wt_data) : '0;
    acc_next = acc_q + wt_term;
    addr     = AddrW'(j_q) * AddrW'(INPUTNUM) + AddrW'(i_q);
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    spk_d   = spk_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    rd_en   = 1'b0;
    valid   = 1'b0;
    done    = 1'b0;
    overrun = 1'b0;

    if (bus.en) begin
      overrun = bus.step_start && (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (bus.step_start) begin
            spk_d   = bus.pre_spike;
            i_d     = '0;
            j_d     = '0;
            acc_d   = '0;
            state_d = StRun;
          end
        end
        StRun: begin
          rd_en = (i_q < ILast);
          acc_d = acc_next;
          if (i_q == ILast) begin
            // Register the result here so acc_sum is stable during the EMIT cycle.
            sum_d   = sat(acc_next);
            idx_d   = j_q;
            state_d = StEmit;
          end else begin
            i_d = i_q + 1'b1;
          end
        end
        StEmit: begin
          valid = 1'b1;
          acc_d = '0;
          i_d   = '0;
          if (j_q == JLast) begin
            done    = 1'b1;
            state_d = StIdle;
          end else begin
            j_d     = j_q + 1'b1;
            state_d = StRun;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      spk_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      spk_q   <= spk_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.wt_rd_en     = rd_en;
  assign bus.wt_addr      = rd_en ? addr : '0;
  assign bus.acc_valid    = valid;
  assign bus.acc_idx      = idx_q;
  assign bus.acc_sum      = sum_q;
  assign bus.busy         = (state_q != StIdle);
  assign bus.step_done    = done;
  assign bus.step_overrun = overrun;
endmodule

// File: tb/tb_snn_step_scheduler.sv
// Directed bench for snn_step_scheduler: table of spike/weight vectors with
// hand-computed sums, plus sequences for overrun, enable stall and mid-step reset.
module tb_snn_step_scheduler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snn_step_scheduler_if bus ();

  snn_step_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Weight RAM: one-cycle read latency, output held while not reading.
  logic signed [23:0] wmem [8];
  always @(posedge clk) begin
    if (bus.wt_rd_en) bus.wt_data <= wmem[bus.wt_addr];
  end

  int w_base [8] = '{1615585, 2564138, -88929, 568763, 592018, -153494, 3681132, 2266863};

  typedef struct {
    int         wsel;
    logic [3:0] spk;
    int         exp0;
    int         exp1;
  } vec_t;
  vec_t vecs [7];

  int nchk = 0;
  int nerr = 0;
  int ev_n, ad_n, ov_n, ov_cyc;
  int ev_cyc [8];
  int ev_idx [8];
  int ev_sum [8];
  int ev_done [8];
  int ad_log [16];
  int busy_log [32];
  int sum_log [32];

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_w(input int wsel);
    for (int k = 0; k < 8; k++) begin
      if (wsel == 0)      wmem[k] = 24'(w_base[k]);
      else if (wsel == 1) wmem[k] = 24'(8388607);
      else                wmem[k] = 24'(-8388608);
    end
  endtask

  // Cycle 0 is the step_start cycle; inputs change #1 after posedge, samples at negedge.
  task automatic run_step(input logic [3:0] spk, input int max_c, input int ovr_at,
                          input int en_at, input int en_len, input int rst_at);
    ev_n = 0; ad_n = 0; ov_n = 0; ov_cyc = -1;
    @(posedge clk); #1;
    bus.step_start = 1'b1;
    bus.pre_spike  = spk;
    bus.en         = 1'b1;
    for (int c = 1; c <= max_c; c++) begin
      @(posedge clk); #1;
      bus.step_start = (c == ovr_at);
      bus.pre_spike  = ~spk;
      bus.en         = !(c >= en_at && c < en_at + en_len);
      rst            = (c == rst_at);
      @(negedge clk);
      busy_log[c] = int'(bus.busy);
      sum_log[c]  = int'(bus.acc_sum);
      if (bus.acc_valid && ev_n < 8) begin
        ev_cyc[ev_n]  = c;
        ev_idx[ev_n]  = int'(bus.acc_idx);
        ev_sum[ev_n]  = int'(bus.acc_sum);
        ev_done[ev_n] = int'(bus.step_done);
        ev_n++;
      end
      if (bus.wt_rd_en && ad_n < 16) begin
        ad_log[ad_n] = int'(bus.wt_addr);
        ad_n++;
      end
      if (bus.step_overrun) begin
        ov_n++;
        ov_cyc = c;
      end
      if (!bus.en) check("rd_en_while_en_low", int'(bus.wt_rd_en), 0);
    end
    bus.step_start = 1'b0;
    bus.en         = 1'b1;
  endtask

  task automatic check_two(input string tag, input int e0, input int e1, input int t0,
                           input int t1);
    check($sformatf("%s_nvalid", tag), ev_n, 2);
    check($sformatf("%s_cyc0", tag), ev_cyc[0], t0);
    check($sformatf("%s_idx0", tag), ev_idx[0], 0);
    check($sformatf("%s_sum0", tag), ev_sum[0], e0);
    check($sformatf("%s_done0", tag), ev_done[0], 0);
    check($sformatf("%s_cyc1", tag), ev_cyc[1], t1);
    check($sformatf("%s_idx1", tag), ev_idx[1], 1);
    check($sformatf("%s_sum1", tag), ev_sum[1], e1);
    check($sformatf("%s_done1", tag), ev_done[1], 1);
  endtask

  task automatic check_addrs(input string tag);
    check($sformatf("%s_naddr", tag), ad_n, 8);
    for (int k = 0; k < 8; k++) check($sformatf("%s_addr%0d", tag, k), ad_log[k], k);
  endtask

  initial begin
    vecs[0] = '{0, 4'b0011, 4179723, 438524};
    vecs[1] = '{0, 4'b1111, 4659557, 6386519};
    vecs[2] = '{0, 4'b0000, 0, 0};
    vecs[3] = '{0, 4'b0100, -88929, 3681132};
    vecs[4] = '{0, 4'b1000, 568763, 2266863};
    vecs[5] = '{1, 4'b1111, 8388607, 8388607};
    vecs[6] = '{2, 4'b1111, -8388608, -8388608};

    rst = 1'b1;
    bus.en = 1'b0;
    bus.step_start = 1'b0;
    bus.pre_spike = '0;
    load_w(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_acc_valid", int'(bus.acc_valid), 0);
    check("rst_acc_sum", int'(bus.acc_sum), 0);
    check("rst_acc_idx", int'(bus.acc_idx), 0);
    check("rst_wt_rd_en", int'(bus.wt_rd_en), 0);
    check("rst_step_done", int'(bus.step_done), 0);
    rst = 1'b0;
    bus.en = 1'b1;

    for (int v = 0; v < 7; v++) begin
      load_w(vecs[v].wsel);
      run_step(vecs[v].spk, 16, -1, -1, 0, -1);
      check_two($sformatf("vec%0d", v), vecs[v].exp0, vecs[v].exp1, 6, 12);
      check($sformatf("vec%0d_overrun", v), ov_n, 0);
      if (v == 0) begin
        check("vec0_busy1", busy_log[1], 1);
        check("vec0_busy12", busy_log[12], 1);
        check("vec0_busy13", busy_log[13], 0);
      end
      if (v == 2) check_addrs("vec2");
    end

    // Overrun mid-RUN and on the step_done cycle, then back-to-back steps.
    load_w(0);
    run_step(4'b0011, 16, 3, -1, 0, -1);
    check("ovr3_count", ov_n, 1);
    check("ovr3_cycle", ov_cyc, 3);
    check_two("ovr3", 4179723, 438524, 6, 12);
    run_step(4'b0011, 16, 12, -1, 0, -1);
    check("ovr12_count", ov_n, 1);
    check("ovr12_cycle", ov_cyc, 12);
    check_two("ovr12", 4179723, 438524, 6, 12);
    check("ovr12_idle_after", busy_log[13], 0);
    run_step(4'b1111, 12, -1, -1, 0, -1);
    check_two("b2b_first", 4659557, 6386519, 6, 12);
    run_step(4'b0011, 16, -1, -1, 0, -1);
    check_two("b2b_second", 4179723, 438524, 6, 12);
    check("b2b_overrun", ov_n, 0);

    // Enable held low for cycles 3..7.
    run_step(4'b0011, 24, -1, 3, 5, -1);
    check_two("en_stall", 4179723, 438524, 11, 17);
    check_addrs("en_stall");
    check("en_stall_busy5", busy_log[5], 1);

    // Reset asserted during cycle 4 of a step.
    run_step(4'b1111, 16, -1, -1, 0, 4);
    check("rst_mid_sum_before", sum_log[3], 438524);
    check("rst_mid_busy_before", busy_log[3], 1);
    check("rst_mid_busy", busy_log[4], 0);
    check("rst_mid_sum", sum_log[4], 0);
    check("rst_mid_nvalid", ev_n, 0);
    run_step(4'b0011, 16, -1, -1, 0, -1);
    check_two("after_rst", 4179723, 438524, 6, 12);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
